// File: rtl/complex_alu_seq_pkg.sv
// Shared execution-stage definitions for the complex unit: widths, opcodes, flags,
// sequencer state encoding, default latencies and the multiply/divide decode helpers.
// Everything the sequencer and the datapath must agree on lives here.
package complex_alu_seq_pkg;

    localparam int SIZE_DATA         = 32;
    localparam int SIZE_OPCODE_I     = 6;
    localparam int SIZE_IMMEDIATE    = 16;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int EXECUTION_FLAGS   = 3;

    // Flag bit positions within flags_o.
    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_EXCEPTION = 1;
    localparam int FLAG_SYSCALL   = 2;

    typedef logic [SIZE_OPCODE_I-1:0] opcode_t;

    localparam opcode_t OP_SYSCALL = 6'h0C;
    localparam opcode_t OP_MULT_L  = 6'h18;
    localparam opcode_t OP_MULT_H  = 6'h19;
    localparam opcode_t OP_MULTU_L = 6'h1A;
    localparam opcode_t OP_MULTU_H = 6'h1B;
    localparam opcode_t OP_DIV_L   = 6'h1C;
    localparam opcode_t OP_DIV_H   = 6'h1D;
    localparam opcode_t OP_DIVU_L  = 6'h1E;
    localparam opcode_t OP_DIVU_H  = 6'h1F;

    localparam int MUL_LAT_DEFAULT = 3;
    localparam int DIV_LAT_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_mul(opcode_t op);
        return (op == OP_MULT_L) || (op == OP_MULT_H) ||
               (op == OP_MULTU_L) || (op == OP_MULTU_H);
    endfunction

    function automatic logic is_div(opcode_t op);
        return (op == OP_DIV_L) || (op == OP_DIV_H) ||
               (op == OP_DIVU_L) || (op == OP_DIVU_H);
    endfunction

    // clog2 of the larger latency; clamped to one bit so a 1/1 configuration
    // still gets a legal counter.
    function automatic int cnt_width(int mul_lat, int div_lat);
        int m;
        int w;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/complex_alu_seq_alu.sv
// Complex_ALU: combinational multiply/divide/syscall datapath.
// Zero cycles of its own; the sequencer provides the multicycle timing.
// _L/_H select the low/high product word or quotient/remainder, zero-extended.
module Complex_ALU
    import complex_alu_seq_pkg::*;
(
    input  opcode_t                       opcode_i,
    input  logic [SIZE_DATA-1:0]          data1_i,
    input  logic [SIZE_DATA-1:0]          data2_i,
    input  logic [SIZE_IMMEDIATE-1:0]     immd_i,
    output logic [2*SIZE_DATA-1:0]        result_o,
    output logic [EXECUTION_FLAGS-1:0]    flags_o
);

    localparam int DW = SIZE_DATA;

    logic [2*DW-1:0] prod_s;
    logic [2*DW-1:0] prod_u;
    logic            div_signed;
    logic            div_zero;
    logic [DW-1:0]   a_mag;
    logic [DW-1:0]   b_mag;
    logic [DW-1:0]   div_a;
    logic [DW-1:0]   div_b;
    logic [DW-1:0]   q_raw;
    logic [DW-1:0]   r_raw;
    logic [DW-1:0]   q_fix;
    logic [DW-1:0]   r_fix;

    // Low 2*DW bits of a product are sign-agnostic, so sign-extend and multiply.
    assign prod_s = {{DW{data1_i[DW-1]}}, data1_i} * {{DW{data2_i[DW-1]}}, data2_i};
    assign prod_u = {{DW{1'b0}}, data1_i} * {{DW{1'b0}}, data2_i};

    // One unsigned divider serves both flavours: signed ops divide magnitudes and
    // fix the signs afterwards (quotient by sign difference, remainder by dividend).
    assign div_signed = (opcode_i == OP_DIV_L) || (opcode_i == OP_DIV_H);
    assign div_zero   = (data2_i == '0);
    assign a_mag      = data1_i[DW-1] ? -data1_i : data1_i;
    assign b_mag      = data2_i[DW-1] ? -data2_i : data2_i;
    assign div_a      = div_signed ? a_mag : data1_i;
    assign div_b      = div_signed ? b_mag : data2_i;
    assign q_raw      = div_zero ? '0 : (div_a / div_b);
    assign r_raw      = div_zero ? '0 : (div_a % div_b);
    assign q_fix      = (div_signed && (data1_i[DW-1] ^ data2_i[DW-1])) ? -q_raw : q_raw;
    assign r_fix      = (div_signed && data1_i[DW-1]) ? -r_raw : r_raw;

    // Select the result word and derive flags for the opcode.
    always_comb begin
        logic [DW-1:0] word;
        logic          known;
        logic          exc;
        logic          sys;
        word  = '0;
        known = 1'b1;
        exc   = 1'b0;
        sys   = 1'b0;
        case (opcode_i)
            OP_MULT_L:  word = prod_s[DW-1:0];
            OP_MULT_H:  word = prod_s[2*DW-1:DW];
            OP_MULTU_L: word = prod_u[DW-1:0];
            OP_MULTU_H: word = prod_u[2*DW-1:DW];
            OP_DIV_L, OP_DIVU_L: begin
                word = div_zero ? '0 : q_fix;
                exc  = div_zero;
            end
            OP_DIV_H, OP_DIVU_H: begin
                word = div_zero ? '0 : r_fix;
                exc  = div_zero;
            end
            OP_SYSCALL: begin
                word = {{(DW-SIZE_IMMEDIATE){1'b0}}, immd_i};
                sys  = 1'b1;
            end
            default:    known = 1'b0;
        endcase
        result_o = known ? {{DW{1'b0}}, word} : '0;
        flags_o  = '0;
        if (known) begin
            flags_o[FLAG_ZERO]      = (word == '0) && !sys;
            flags_o[FLAG_EXCEPTION] = exc;
            flags_o[FLAG_SYSCALL]   = sys;
        end
    end

endmodule

// File: rtl/complex_alu_seq.sv
// complex_alu_seq: IDLE/BUSY/DONE sequencer around Complex_ALU giving multicycle timing.
// Latency MUL_LAT / DIV_LAT / 1 cycles from accept edge to result_valid_o.
// Result held in DONE until result_ready_i; a new op may be accepted on the consume cycle.
module complex_alu_seq
    import complex_alu_seq_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  opcode_t                       opcode_i,
    input  logic [SIZE_DATA-1:0]          data1_i,
    input  logic [SIZE_DATA-1:0]          data2_i,
    input  logic [SIZE_IMMEDIATE-1:0]     immd_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  dest_tag_i,
    input  logic                          flush_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [2*SIZE_DATA-1:0]        result_o,
    output logic [EXECUTION_FLAGS-1:0]    flags_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  dest_tag_o,
    output logic                          busy_o
);

    // MUL_LAT and DIV_LAT must both be at least 1.
    localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);

    state_e                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    opcode_t                        opcode_q;
    logic [SIZE_DATA-1:0]           data1_q;
    logic [SIZE_DATA-1:0]           data2_q;
    logic [SIZE_IMMEDIATE-1:0]      immd_q;
    logic [SIZE_PHYSICAL_LOG-1:0]   tag_q;
    logic                           valid_q;
    logic [2*SIZE_DATA-1:0]         result_q;
    logic [EXECUTION_FLAGS-1:0]     flags_q;
    logic [SIZE_PHYSICAL_LOG-1:0]   dest_tag_q;

    logic                           accept_d;
    logic [CNT_W-1:0]               load_d;
    opcode_t                        opcode_d;
    logic [SIZE_DATA-1:0]           data1_d;
    logic [SIZE_DATA-1:0]           data2_d;
    logic [SIZE_IMMEDIATE-1:0]      immd_d;
    logic [SIZE_PHYSICAL_LOG-1:0]   tag_d;
    logic [2*SIZE_DATA-1:0]         dp_result;
    logic [EXECUTION_FLAGS-1:0]     dp_flags;

    assign issue_ready_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && result_ready_i);
    assign accept_d      = issue_valid_i && issue_ready_o && !flush_i;

    // The datapath normally sees the latched operands; on an accept it sees the
    // incoming ones so a single-cycle op can be registered at its accept edge.
    assign opcode_d = accept_d ? opcode_i   : opcode_q;
    assign data1_d  = accept_d ? data1_i    : data1_q;
    assign data2_d  = accept_d ? data2_i    : data2_q;
    assign immd_d   = accept_d ? immd_i     : immd_q;
    assign tag_d    = accept_d ? dest_tag_i : tag_q;

    // Counter preload is latency-1 of the incoming op.
    always_comb begin
        load_d = '0;
        if (is_mul(opcode_i)) begin
            load_d = CNT_W'(MUL_LAT - 1);
        end else if (is_div(opcode_i)) begin
            load_d = CNT_W'(DIV_LAT - 1);
        end
    end

    Complex_ALU u_alu (
        .opcode_i (opcode_d),
        .data1_i  (data1_d),
        .data2_i  (data2_d),
        .immd_i   (immd_d),
        .result_o (dp_result),
        .flags_o  (dp_flags)
    );

    // Sequencer FSM: flush beats everything, then accept, then count/complete/consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            opcode_q   <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            immd_q     <= '0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            dest_tag_q <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (accept_d) begin
            opcode_q <= opcode_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            immd_q   <= immd_d;
            tag_q    <= tag_d;
            cnt_q    <= load_d;
            if (load_d == '0) begin
                state_q    <= ST_DONE;
                valid_q    <= 1'b1;
                result_q   <= dp_result;
                flags_q    <= dp_flags;
                dest_tag_q <= tag_d;
            end else begin
                state_q <= ST_BUSY;
                valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q    <= ST_DONE;
                        valid_q    <= 1'b1;
                        result_q   <= dp_result;
                        flags_q    <= dp_flags;
                        dest_tag_q <= tag_d;
                    end
                end
                ST_DONE: begin
                    if (result_ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign flags_o        = flags_q;
    assign dest_tag_o     = dest_tag_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_complex_alu_seq.sv
// Directed bench for complex_alu_seq: latency, hold, divide-by-zero, back-to-back,
// flush and asynchronous reset. Expected results come from an independent longint
// model pushed to a scoreboard at issue time and popped when result_valid_o appears.
module tb_complex_alu_seq;
    import complex_alu_seq_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  flg;
        logic [6:0]  tag;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    opcode_t     opcode_i = '0;
    logic [31:0] data1_i = '0;
    logic [31:0] data2_i = '0;
    logic [15:0] immd_i = '0;
    logic [6:0]  dest_tag_i = '0;
    logic        flush_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [63:0] result_o;
    logic [2:0]  flags_o;
    logic [6:0]  dest_tag_o;
    logic        busy_o;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    complex_alu_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .opcode_i       (opcode_i),
        .data1_i        (data1_i),
        .data2_i        (data2_i),
        .immd_i         (immd_i),
        .dest_tag_i     (dest_tag_i),
        .flush_i        (flush_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .flags_o        (flags_o),
        .dest_tag_o     (dest_tag_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(opcode_t op);
        if (op inside {OP_MULT_L, OP_MULT_H, OP_MULTU_L, OP_MULTU_H}) return MUL_LAT;
        if (op inside {OP_DIV_L, OP_DIV_H, OP_DIVU_L, OP_DIVU_H}) return DIV_LAT;
        return 1;
    endfunction

    // Reference model: returns {flags, result}.
    function automatic logic [66:0] model(opcode_t op, logic [31:0] a, logic [31:0] b,
                                          logic [15:0] imm);
        longint      sa, sb2, t;
        logic [63:0] pu;
        logic [31:0] w;
        logic        exc;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        pu  = 64'(a) * 64'(b);
        w   = '0;
        exc = 1'b0;
        case (op)
            OP_MULT_L:  begin t = sa * sb2; w = t[31:0]; end
            OP_MULT_H:  begin t = sa * sb2; w = t[63:32]; end
            OP_MULTU_L: w = pu[31:0];
            OP_MULTU_H: w = pu[63:32];
            OP_DIV_L:   if (b == 0) exc = 1'b1; else begin t = sa / sb2; w = t[31:0]; end
            OP_DIV_H:   if (b == 0) exc = 1'b1; else begin t = sa % sb2; w = t[31:0]; end
            OP_DIVU_L:  if (b == 0) exc = 1'b1; else w = a / b;
            OP_DIVU_H:  if (b == 0) exc = 1'b1; else w = a % b;
            OP_SYSCALL: return {3'b100, 48'h0, imm};
            default:    return '0;
        endcase
        return {1'b0, exc, (w == 0), 32'h0, w};
    endfunction

    task automatic issue(input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [6:0] tag);
        logic [66:0] m;
        opcode_i      = op;
        data1_i       = a;
        data2_i       = b;
        immd_i        = imm;
        dest_tag_i    = tag;
        issue_valid_i = 1'b1;
        #1;
        check("issue_ready", issue_ready_o, 1);
        m = model(op, a, b, imm);
        sb.push_back('{res: m[63:0], flg: m[66:64], tag: tag, due: cyc + lat_of(op)});
        step();
        issue_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int   waited;
        exp_t e;
        waited = 0;
        while (!result_valid_o && waited < 40) begin
            step();
            waited++;
        end
        if (!result_valid_o) begin
            check({name, ":timeout"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check({name, ":unexpected"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({name, ":latency_cycle"}, 64'(cyc), 64'(e.due));
        check({name, ":result"}, result_o, e.res);
        check({name, ":flags"}, 64'(flags_o), 64'(e.flg));
        check({name, ":tag"}, 64'(dest_tag_o), 64'(e.tag));
    endtask

    task automatic consume(input string name);
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        check({name, ":valid_after_consume"}, result_valid_o, 0);
    endtask

    task automatic hold(input string name, input int n);
        logic [63:0] r;
        logic [2:0]  f;
        logic [6:0]  t;
        r = result_o;
        f = flags_o;
        t = dest_tag_o;
        for (int i = 0; i < n; i++) begin
            step();
            check({name, ":held_valid"}, result_valid_o, 1);
            check({name, ":held_ready"}, issue_ready_o, 0);
            check({name, ":held_result"}, result_o, r);
            check({name, ":held_flags_tag"}, {f, t}, {flags_o, dest_tag_o});
        end
    endtask

    task automatic watch_no_valid(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (result_valid_o) seen = 1'b1;
            step();
        end
        check({name, ":no_valid"}, seen, 0);
    endtask

    initial begin
        int c;

        // Reset values, no clock edge yet.
        #2;
        check("rst:valid", result_valid_o, 0);
        check("rst:busy", busy_o, 0);
        check("rst:result", result_o, 0);
        check("rst:flags_tag", {flags_o, dest_tag_o}, 0);
        step();
        step();
        reset = 1'b0;
        step();
        check("rst:issue_ready", issue_ready_o, 1);

        // Multiply 7 * -3, consumed immediately.
        issue(OP_MULT_L, 32'd7, 32'hFFFFFFFD, 16'h0, 7'd5);
        check("mult_l:busy", busy_o, 1);
        wait_result("mult_l");
        consume("mult_l");
        issue(OP_MULT_H, 32'd7, 32'hFFFFFFFD, 16'h0, 7'd6);
        wait_result("mult_h");
        consume("mult_h");
        issue(OP_MULTU_H, 32'hFFFFFFFF, 32'd2, 16'h0, 7'd7);
        wait_result("multu_h");
        consume("multu_h");

        // Unsigned divide held for five cycles before consume.
        issue(OP_DIVU_L, 32'd100, 32'd7, 16'h0, 7'd9);
        wait_result("divu_l");
        hold("divu_l", 5);
        consume("divu_l");
        check("divu_l:idle", busy_o, 0);

        issue(OP_DIVU_H, 32'd100, 32'd7, 16'h0, 7'd10);
        wait_result("divu_h");
        consume("divu_h");
        issue(OP_DIV_L, -32'sd100, 32'd7, 16'h0, 7'd11);
        wait_result("div_l_neg");
        consume("div_l_neg");
        issue(OP_DIV_H, -32'sd100, 32'd7, 16'h0, 7'd12);
        wait_result("div_h_neg");
        consume("div_h_neg");

        // Divide by zero.
        issue(OP_DIV_L, 32'd5, 32'd0, 16'h0, 7'd13);
        wait_result("div_zero");
        check("div_zero:exc_bit", flags_o[1], 1);
        consume("div_zero");

        // Unrecognised opcode completes in one cycle with zeros.
        issue(6'h3F, 32'd9, 32'd9, 16'hBEEF, 7'd14);
        wait_result("unknown_op");
        consume("unknown_op");

        // Back-to-back: SYSCALL held one cycle, MULTU_H issued on the consume cycle.
        issue(OP_SYSCALL, 32'd0, 32'd0, 16'h1234, 7'd20);
        wait_result("syscall");
        step();
        check("b2b:syscall_still_valid", result_valid_o, 1);
        result_ready_i = 1'b1;
        issue(OP_MULTU_H, 32'h80000000, 32'h00000010, 16'h0, 7'd21);
        result_ready_i = 1'b0;
        check("b2b:busy_no_gap", busy_o, 1);
        check("b2b:valid_dropped", result_valid_o, 0);
        wait_result("b2b_multu_h");
        consume("b2b_multu_h");

        // Flush during cycle 4 of a divide.
        c = cyc;
        issue(OP_DIV_L, 32'd50, 32'd3, 16'h0, 7'd30);
        void'(sb.pop_back());
        while (cyc < c + 4) step();
        check("flush:busy_before", busy_o, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush:idle", busy_o, 0);
        check("flush:valid", result_valid_o, 0);
        watch_no_valid("flush", 12);
        issue(OP_MULT_L, 32'd123, 32'd45, 16'h0, 7'd31);
        wait_result("after_flush");
        consume("after_flush");

        // Asynchronous reset between edges while BUSY.
        issue(OP_DIVU_L, 32'd1000, 32'd10, 16'h0, 7'd40);
        void'(sb.pop_back());
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        check("async_rst:valid", result_valid_o, 0);
        check("async_rst:result", result_o, 0);
        check("async_rst:flags_tag", {flags_o, dest_tag_o}, 0);
        check("async_rst:busy", busy_o, 0);
        step();
        reset = 1'b0;
        step();
        check("async_rst:issue_ready", issue_ready_o, 1);
        watch_no_valid("async_rst", 12);
        issue(OP_DIVU_H, 32'd1000, 32'd7, 16'h0, 7'd41);
        wait_result("after_reset");
        consume("after_reset");

        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
